// File: rtl/ps2_key_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encoding, scan-code
// prefixes and the debug view of the receiver's internal state.
package ps2_key_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  typedef struct packed {
    ps2_state_t state;
    logic [2:0] bit_cnt;
    logic       ext_pending;
    logic       brk_pending;
  } ps2_dbg_t;

  // Odd parity: the eight data bits plus the parity bit hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_rx_sync.sv
// Multi-stage synchronizer for one raw PS/2 line; resets to the bus-idle
// level (1) so no false falling edge appears after reset.
module ps2_sync #(
  parameter int STAGES = 2
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames and tracks make/break
// codes to report the currently held key.
module ps2_key_rx
  import ps2_key_rx_pkg::*;
#(
  parameter int TIMEOUT     = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       key_clk,
  input  logic       key_data,
  output logic [7:0] KeyCode,
  output logic       code_valid,
  output logic [7:0] scan_code,
  output logic       frame_err,
  output ps2_dbg_t   o_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          w_kclk_s, w_kdat_s;
  logic          r_kclk_prev, r_fall, r_fdat;
  ps2_state_t    r_state, w_next;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_key_code, r_scan_code;
  logic          r_code_valid, r_frame_err;
  logic          r_ext_pending, r_brk_pending;
  logic          w_timeout, w_start_err, w_good, w_bad;

  ps2_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .Clk (Clk), .Rst (Rst), .i_d (key_clk),  .o_q (w_kclk_s)
  );
  ps2_sync #(.STAGES(SYNC_STAGES)) u_sync_dat (
    .Clk (Clk), .Rst (Rst), .i_d (key_data), .o_q (w_kdat_s)
  );

  // The fall pulse is registered together with the data sample it qualifies.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_kclk_prev <= 1'b1;
      r_fall      <= 1'b0;
      r_fdat      <= 1'b1;
    end else begin
      r_kclk_prev <= w_kclk_s;
      r_fall      <= r_kclk_prev & ~w_kclk_s;
      r_fdat      <= w_kdat_s;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = S_IDLE;
    end else if (r_fall) begin
      case (r_state)
        S_IDLE:   if (!r_fdat) w_next = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_next = S_PARITY;
        S_PARITY: w_next = S_STOP;
        S_STOP:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_timeout   = (r_state != S_IDLE) && !r_fall && (r_to_cnt == TW'(TIMEOUT - 1));
    w_start_err = (r_state == S_IDLE) && r_fall && r_fdat;
    w_good      = (r_state == S_STOP) && r_fall && r_fdat && odd_parity_ok(r_shift, r_parity);
    w_bad       = (r_state == S_STOP) && r_fall && !w_good;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      r_to_cnt      <= '0;
      r_key_code    <= '0;
      r_scan_code   <= '0;
      r_code_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_ext_pending <= 1'b0;
      r_brk_pending <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;

      if (r_state == S_IDLE || r_fall || w_timeout) r_to_cnt <= '0;
      else                                          r_to_cnt <= r_to_cnt + 1'b1;

      if (w_timeout) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (r_fall) begin
        case (r_state)
          S_IDLE: begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
          end
          S_DATA: begin
            r_shift   <= {r_fdat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          S_PARITY: r_parity <= r_fdat;
          default:  ;
        endcase
      end

      if (w_start_err || w_bad) r_frame_err <= 1'b1;

      if (w_good) begin
        r_frame_err <= 1'b0;
        if (r_shift == PS2_EXT) begin
          r_ext_pending <= 1'b1;
        end else if (r_shift == PS2_BRK) begin
          r_brk_pending <= 1'b1;
        end else begin
          r_scan_code   <= r_shift;
          r_code_valid  <= 1'b1;
          r_ext_pending <= 1'b0;
          r_brk_pending <= 1'b0;
          // A break only releases the key it names; stale breaks are ignored.
          if (!r_brk_pending)             r_key_code <= r_shift;
          else if (r_shift == r_key_code) r_key_code <= 8'h00;
        end
      end
    end
  end

  assign KeyCode           = r_key_code;
  assign scan_code         = r_scan_code;
  assign code_valid        = r_code_valid;
  assign frame_err         = r_frame_err;
  assign o_dbg.state       = r_state;
  assign o_dbg.bit_cnt     = r_bit_cnt;
  assign o_dbg.ext_pending = r_ext_pending;
  assign o_dbg.brk_pending = r_brk_pending;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: a frame-level key-state model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ps2_key_rx;
  import ps2_key_rx_pkg::*;

  localparam int TIMEOUT = 100;
  localparam int SYNC    = 2;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_clk = 1'b1;
  logic       key_data = 1'b1;
  logic [7:0] key_code, scan_code;
  logic       code_valid, frame_err;
  ps2_dbg_t   dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse = 0;
  int cyc     = 0;
  int fall11_cyc = 0;
  int pulse_cyc  = 0;

  logic [7:0] exp_key = 8'h00, exp_scan = 8'h00;
  logic       exp_valid = 1'b0, exp_err = 1'b0, m_brk = 1'b0;
  logic [10:0] exp_q[$];

  ps2_key_rx #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .key_clk    (key_clk),
    .key_data   (key_data),
    .KeyCode    (key_code),
    .code_valid (code_valid),
    .scan_code  (scan_code),
    .frame_err  (frame_err),
    .o_dbg      (dbg)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a complete frame takes effect SYNC+2 Clk edges after the edge
  // that drove the 11th key_clk low, i.e. SYNC+1 after the edge sampling it.
  initial begin
    logic [10:0] b;
    logic [7:0]  d;
    forever begin
      wait (exp_q.size() != 0);
      b = exp_q.pop_front();
      repeat (SYNC + 2) @(posedge clk);
      d = b[8:1];
      if (b[0] == 1'b0 && (^b[9:1]) == 1'b1 && b[10] == 1'b1) begin
        exp_err = 1'b0;
        if (d == 8'hF0) begin
          m_brk = 1'b1;
        end else if (d != 8'hE0) begin
          exp_scan  = d;
          exp_valid = 1'b1;
          if (!m_brk)             exp_key = d;
          else if (d == exp_key)  exp_key = 8'h00;
          m_brk = 1'b0;
        end
      end else begin
        exp_err = 1'b1;
      end
      @(posedge clk);
      exp_valid = 1'b0;
    end
  end

  // Scoreboard compare, every cycle on the inactive edge
  always @(negedge clk) begin
    check("KeyCode",    {24'd0, key_code},   {24'd0, exp_key});
    check("scan_code",  {24'd0, scan_code},  {24'd0, exp_scan});
    check("code_valid", {31'd0, code_valid}, {31'd0, exp_valid});
    check("frame_err",  {31'd0, frame_err},  {31'd0, exp_err});
    if (code_valid) begin
      n_pulse++;
      pulse_cyc = cyc;
    end
  end

  // Driver: device changes data while key_clk is high; nbits < 11 gives a partial frame
  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit stop_bit, input int nbits);
    logic [10:0] b;
    b = {stop_bit, (~^d) ^ flip_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      key_data = b[i];
      repeat (HALF / 2) @(negedge clk);
      key_clk = 1'b0;
      if (i == 10) begin
        fall11_cyc = cyc;
        exp_q.push_back(b);
      end
      repeat (HALF) @(negedge clk);
      key_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end
    key_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b1, 11);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst      = 1'b1;
    key_clk  = 1'b1;
    key_data = 1'b1;
    exp_key  = 8'h00;
    exp_scan = 8'h00;
    exp_err  = 1'b0;
    exp_valid = 1'b0;
    m_brk    = 1'b0;
  endtask

  task automatic release_reset();
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int p;
    do_reset();
    #1;
    check("rst_KeyCode",   {24'd0, key_code},   32'h00);
    check("rst_scan_code", {24'd0, scan_code},  32'h00);
    check("rst_valid",     {31'd0, code_valid}, 32'h0);
    check("rst_err",       {31'd0, frame_err},  32'h0);
    check("rst_state",     {30'd0, dbg.state},  32'h0);
    release_reset();

    // Single make code
    p = n_pulse;
    key(8'h1C);
    check("make_KeyCode", {24'd0, key_code},  32'h1C);
    check("make_scan",    {24'd0, scan_code}, 32'h1C);
    check("make_err",     {31'd0, frame_err}, 32'h0);
    check("make_pulses",  n_pulse - p,        32'd1);

    // Make then break
    key(8'hF0);
    key(8'h1C);
    check("break_KeyCode", {24'd0, key_code}, 32'h00);
    check("break_pulses",  n_pulse - p,       32'd2);

    // Break of a key that is not held leaves KeyCode alone
    key(8'h1C);
    key(8'hF0);
    key(8'h23);
    check("stale_break_KeyCode", {24'd0, key_code},  32'h1C);
    check("stale_break_scan",    {24'd0, scan_code}, 32'h23);

    // Parity error, then recovery
    p = n_pulse;
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    check("par_err",     {31'd0, frame_err}, 32'h1);
    check("par_KeyCode", {24'd0, key_code},  32'h1C);
    check("par_scan",    {24'd0, scan_code}, 32'h23);
    check("par_pulses",  n_pulse - p,        32'd0);
    key(8'h23);
    check("recover_err",     {31'd0, frame_err}, 32'h0);
    check("recover_KeyCode", {24'd0, key_code},  32'h23);

    // Typematic repeat
    p = n_pulse;
    key(8'h23);
    key(8'h23);
    check("repeat_pulses",  n_pulse - p,       32'd2);
    check("repeat_KeyCode", {24'd0, key_code}, 32'h23);

    // Extended make and extended break
    key(8'hE0);
    key(8'h75);
    check("ext_make", {24'd0, key_code}, 32'h75);
    key(8'hE0);
    key(8'hF0);
    key(8'h75);
    check("ext_break", {24'd0, key_code}, 32'h00);

    // Partial frame abandoned by timeout
    send_frame(8'h00, 1'b0, 1'b1, 5);
    repeat (TIMEOUT + 30) @(negedge clk);
    key(8'h29);
    check("timeout_KeyCode", {24'd0, key_code},  32'h29);
    check("timeout_err",     {31'd0, frame_err}, 32'h0);

    // Break prefix survives a timed-out frame
    key(8'hF0);
    send_frame(8'h00, 1'b0, 1'b1, 5);
    repeat (TIMEOUT + 30) @(negedge clk);
    key(8'h29);
    check("pending_timeout_KeyCode", {24'd0, key_code}, 32'h00);

    // Bad stop bit
    key(8'h1C);
    send_frame(8'h11, 1'b0, 1'b0, 11);
    check("stop_err",     {31'd0, frame_err}, 32'h1);
    check("stop_KeyCode", {24'd0, key_code},  32'h1C);

    // Reset in the middle of a frame
    send_frame(8'h5A, 1'b0, 1'b1, 6);
    do_reset();
    #1;
    check("midrst_KeyCode", {24'd0, key_code},  32'h00);
    check("midrst_scan",    {24'd0, scan_code}, 32'h00);
    check("midrst_err",     {31'd0, frame_err}, 32'h0);
    check("midrst_valid",   {31'd0, code_valid}, 32'h0);
    release_reset();
    p = n_pulse;
    key(8'h1C);
    check("post_rst_KeyCode", {24'd0, key_code}, 32'h1C);
    check("post_rst_pulses",  n_pulse - p,       32'd1);
    check("latency",          pulse_cyc - fall11_cyc, SYNC + 2);

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
